// File: rtl/gpu_launch_ctrl_pkg.sv
// Shared types and register map for the GPU kernel launch controller.
// Also holds the small counter helper used by the control FSM.
package gpu_launch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_EN,
        GAP,
        WR_START,
        WAIT_IRQ,
        WR_CLR,
        DONE
    } launch_state_e;

    typedef enum logic {
        OBI_ADDR,
        OBI_RESP
    } obi_state_e;

    localparam logic [31:0] CONF_ENABLE_ADDR = 32'h0000_0000;
    localparam logic [31:0] CONF_START_ADDR  = 32'h0000_0004;
    localparam logic [31:0] CONF_CLEAR_ADDR  = 32'h0000_0008;
    localparam logic [31:0] CONF_WDATA       = 32'h0000_0001;
    localparam logic [3:0]  CONF_BE          = 4'b1111;

    // Down-counter step that holds at zero instead of wrapping.
    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/gpu_launch_ctrl_if.sv
// OBI write channel between the launch controller and the GPU configuration registers.
interface gpu_launch_ctrl_if;
    logic        req_o;
    logic        gnt_i;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic        rvalid_i;

    modport master (
        output req_o, we_o, be_o, addr_o, wdata_o,
        input  gnt_i, rvalid_i
    );

    modport slave (
        input  req_o, we_o, be_o, addr_o, wdata_o,
        output gnt_i, rvalid_i
    );
endinterface

// File: rtl/obi_single_write.sv
// One OBI full-word write: address phase held until grant, then wait for rvalid.
// done pulses combinationally in the response cycle so the caller can advance on that edge.
module obi_single_write
    import gpu_launch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              done,
    gpu_launch_ctrl_if.master obi
);

    obi_state_e state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OBI_ADDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        done           = 1'b0;
        obi.req_o      = 1'b0;
        obi.we_o       = 1'b0;
        obi.be_o       = 4'b0000;
        obi.addr_o     = 32'd0;
        obi.wdata_o    = 32'd0;
        case (state)
            OBI_ADDR: begin
                if (go) begin
                    obi.req_o   = 1'b1;
                    obi.we_o    = 1'b1;
                    obi.be_o    = CONF_BE;
                    obi.addr_o  = addr;
                    obi.wdata_o = wdata;
                    if (obi.gnt_i) begin
                        state_nxt = OBI_RESP;
                    end
                end
            end
            // rvalid only counts once the grant edge has moved us here.
            OBI_RESP: begin
                if (obi.rvalid_i) begin
                    done      = 1'b1;
                    state_nxt = OBI_ADDR;
                end
            end
            default: state_nxt = OBI_ADDR;
        endcase
    end

endmodule

// File: rtl/gpu_launch_ctrl.sv
// Kernel launch sequencer: enable write, fixed gap, start write, wait for the
// completion interrupt (optionally bounded), clear write, one-cycle done.
module gpu_launch_ctrl
    import gpu_launch_ctrl_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 50,
    parameter int unsigned IRQ_TIMEOUT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              launch_i,
    input  logic              interrupt_i,
    gpu_launch_ctrl_if.master obi,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o
);

    localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES);
    localparam logic [31:0] TO_LOAD  = 32'(IRQ_TIMEOUT);

    launch_state_e state, state_nxt;
    logic [31:0]   gap_cnt, gap_cnt_nxt;
    logic [31:0]   to_cnt, to_cnt_nxt;
    logic          timeout_q, timeout_nxt;
    logic          wr_go;
    logic          wr_done;
    logic [31:0]   wr_addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            gap_cnt   <= 32'd0;
            to_cnt    <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_cnt_nxt;
            to_cnt    <= to_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        to_cnt_nxt  = to_cnt;
        timeout_nxt = timeout_q;
        wr_go       = 1'b0;
        wr_addr     = 32'd0;
        case (state)
            IDLE: begin
                if (launch_i) begin
                    state_nxt   = WR_EN;
                    timeout_nxt = 1'b0;
                end
            end
            WR_EN: begin
                wr_go   = 1'b1;
                wr_addr = CONF_ENABLE_ADDR;
                if (wr_done) begin
                    if (GAP_LOAD == 32'd0) begin
                        state_nxt = WR_START;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_LOAD;
                    end
                end
            end
            // Counter holds the cycles still to spend here, including this one.
            GAP: begin
                gap_cnt_nxt = sat_dec(gap_cnt);
                if (gap_cnt <= 32'd1) begin
                    state_nxt = WR_START;
                end
            end
            WR_START: begin
                wr_go   = 1'b1;
                wr_addr = CONF_START_ADDR;
                if (wr_done) begin
                    state_nxt  = WAIT_IRQ;
                    to_cnt_nxt = TO_LOAD;
                end
            end
            WAIT_IRQ: begin
                to_cnt_nxt = sat_dec(to_cnt);
                if (interrupt_i) begin
                    state_nxt = WR_CLR;
                end else if (TO_LOAD != 32'd0 && to_cnt <= 32'd1) begin
                    state_nxt   = WR_CLR;
                    timeout_nxt = 1'b1;
                end
            end
            WR_CLR: begin
                wr_go   = 1'b1;
                wr_addr = CONF_CLEAR_ADDR;
                if (wr_done) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    obi_single_write u_wr (
        .clk   (clk_i),
        .rst   (rst_i),
        .go    (wr_go),
        .addr  (wr_addr),
        .wdata (CONF_WDATA),
        .done  (wr_done),
        .obi   (obi)
    );

    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_gpu_launch_ctrl.sv
// Directed bench for gpu_launch_ctrl: a GAP=3/timeout=20 instance and a GAP=0/no-timeout instance
// behind a zero-wait OBI responder with an optional grant stall on the start write.
module tb_gpu_launch_ctrl;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic launch_a = 1'b0;
    logic irq_a    = 1'b0;
    logic launch_b = 1'b0;
    logic irq_b    = 1'b0;
    logic busy_a, done_a, to_a;
    logic busy_b, done_b, to_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int stall_req_a  = 0;
    int stall_used_a = 0;

    logic [31:0] wa_addr_a [$];
    logic [31:0] wa_data_a [$];
    logic [31:0] wa_addr_b [$];
    logic [31:0] wa_data_b [$];
    int rise_a [$];
    int rv_a   [$];
    int rise_b [$];
    int rv_b   [$];
    logic req_prev_a = 1'b0;
    logic req_prev_b = 1'b0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int req4_cnt_a = 0;
    int req4_ok_a  = 0;
    int idle_bad   = 0;

    always #5 clk = ~clk;

    gpu_launch_ctrl_if obi_a ();
    gpu_launch_ctrl_if obi_b ();

    gpu_launch_ctrl #(.GAP_CYCLES(3), .IRQ_TIMEOUT(20)) dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .launch_i    (launch_a),
        .interrupt_i (irq_a),
        .obi         (obi_a),
        .busy_o      (busy_a),
        .done_o      (done_a),
        .timeout_o   (to_a)
    );

    gpu_launch_ctrl #(.GAP_CYCLES(0), .IRQ_TIMEOUT(0)) dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .launch_i    (launch_b),
        .interrupt_i (irq_b),
        .obi         (obi_b),
        .busy_o      (busy_b),
        .done_o      (done_b),
        .timeout_o   (to_b)
    );

    // Responder: grant withheld for stall_req_a cycles on each start-write address phase.
    assign obi_a.gnt_i = !(obi_a.req_o && obi_a.addr_o == 32'h4 && stall_used_a < stall_req_a);
    assign obi_b.gnt_i = 1'b1;

    always @(posedge clk) begin
        cyc            <= cyc + 1;
        obi_a.rvalid_i <= obi_a.req_o && obi_a.gnt_i;
        obi_b.rvalid_i <= obi_b.req_o && obi_b.gnt_i;
        if (obi_a.req_o && obi_a.addr_o == 32'h4) begin
            if (!obi_a.gnt_i) stall_used_a <= stall_used_a + 1;
        end else begin
            stall_used_a <= 0;
        end
    end

    always @(negedge clk) begin
        if (obi_a.req_o && obi_a.gnt_i) begin
            wa_addr_a.push_back(obi_a.addr_o);
            wa_data_a.push_back(obi_a.wdata_o);
        end
        if (obi_b.req_o && obi_b.gnt_i) begin
            wa_addr_b.push_back(obi_b.addr_o);
            wa_data_b.push_back(obi_b.wdata_o);
        end
        if (obi_a.req_o && !req_prev_a) rise_a.push_back(cyc);
        if (obi_b.req_o && !req_prev_b) rise_b.push_back(cyc);
        if (obi_a.rvalid_i) rv_a.push_back(cyc);
        if (obi_b.rvalid_i) rv_b.push_back(cyc);
        req_prev_a <= obi_a.req_o;
        req_prev_b <= obi_b.req_o;
        done_cnt_a <= done_cnt_a + (done_a ? 1 : 0);
        done_cnt_b <= done_cnt_b + (done_b ? 1 : 0);
        if (obi_a.req_o && obi_a.addr_o == 32'h4) begin
            req4_cnt_a <= req4_cnt_a + 1;
            if (obi_a.wdata_o == 32'd1 && obi_a.we_o && obi_a.be_o == 4'hF)
                req4_ok_a <= req4_ok_a + 1;
        end
        if ((!obi_a.req_o && (obi_a.we_o || obi_a.be_o != 4'd0 || obi_a.addr_o != 32'd0 || obi_a.wdata_o != 32'd0)) ||
            (!obi_b.req_o && (obi_b.we_o || obi_b.be_o != 4'd0 || obi_b.addr_o != 32'd0 || obi_b.wdata_o != 32'd0)))
            idle_bad <= idle_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_a();
        launch_a = 1'b1;
        tick(1);
        launch_a = 1'b0;
    endtask

    task automatic pulse_b();
        launch_b = 1'b1;
        tick(1);
        launch_b = 1'b0;
    endtask

    task automatic wait_rv_a(input int target);
        int n = 0;
        while (rv_a.size() < target && n < 200) begin tick(1); n++; end
        check("wait_rv_a", 32'(rv_a.size() >= target), 32'd1);
    endtask

    task automatic wait_rv_b(input int target);
        int n = 0;
        while (rv_b.size() < target && n < 200) begin tick(1); n++; end
        check("wait_rv_b", 32'(rv_b.size() >= target), 32'd1);
    endtask

    task automatic wait_rise_a(input int target);
        int n = 0;
        while (rise_a.size() < target && n < 200) begin tick(1); n++; end
        check("wait_rise_a", 32'(rise_a.size() >= target), 32'd1);
    endtask

    task automatic wait_req4_a();
        int n = 0;
        while (!(obi_a.req_o && obi_a.addr_o == 32'h4) && n < 200) begin tick(1); n++; end
        check("wait_req4_a", 32'(obi_a.req_o && obi_a.addr_o == 32'h4), 32'd1);
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!done_a && n < 200) begin tick(1); n++; end
        check("wait_done_a", 32'(done_a), 32'd1);
    endtask

    task automatic wait_done_b();
        int n = 0;
        while (!done_b && n < 200) begin tick(1); n++; end
        check("wait_done_b", 32'(done_b), 32'd1);
    endtask

    task automatic check_seq(input int id, input int base);
        logic [31:0] exp_addr [3];
        int sz;
        exp_addr = '{32'h0, 32'h4, 32'h8};
        sz = (id == 0) ? wa_addr_a.size() : wa_addr_b.size();
        check($sformatf("wr_count_%0d", id), 32'(sz - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < sz) begin
                check($sformatf("wr_addr_%0d_%0d", id, i),
                      (id == 0) ? wa_addr_a[base + i] : wa_addr_b[base + i], exp_addr[i]);
                check($sformatf("wr_data_%0d_%0d", id, i),
                      (id == 0) ? wa_data_a[base + i] : wa_data_b[base + i], 32'd1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int wb, rb, sb, db, r4b, okb, irq_cyc;

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_timeout", 32'(to_a), 32'd0);
        check("rst_req", 32'(obi_a.req_o), 32'd0);
        check("rst_addr", obi_a.addr_o, 32'd0);

        // Zero-wait sequence with interrupt 10 cycles after the start write.
        wb = wa_addr_a.size(); rb = rv_a.size(); sb = rise_a.size(); db = done_cnt_a;
        pulse_a();
        check("busy_after_launch", 32'(busy_a), 32'd1);
        wait_rv_a(rb + 2);
        tick(10);
        irq_a = 1'b1; irq_cyc = cyc;
        wait_done_a();
        irq_a = 1'b0;
        tick(2);
        check_seq(0, wb);
        if (rise_a.size() >= sb + 3 && rv_a.size() >= rb + 1) begin
            check("gap_start_latency", 32'(rise_a[sb + 1] - rv_a[rb]), 32'd4);
            check("irq_to_clear", 32'(rise_a[sb + 2]), 32'(irq_cyc + 1));
        end
        check("done_pulses", 32'(done_cnt_a - db), 32'd1);
        check("no_timeout", 32'(to_a), 32'd0);

        // Grant held off for 5 cycles on the start write.
        stall_req_a = 5;
        wb = wa_addr_a.size(); rb = rv_a.size(); db = done_cnt_a;
        r4b = req4_cnt_a; okb = req4_ok_a;
        pulse_a();
        wait_rv_a(rb + 2);
        tick(1);
        irq_a = 1'b1;
        wait_done_a();
        irq_a = 1'b0;
        stall_req_a = 0;
        tick(2);
        check_seq(0, wb);
        check("stall_req_cycles", 32'(req4_cnt_a - r4b), 32'd6);
        check("stall_stable", 32'(req4_ok_a - okb), 32'd6);
        check("stall_done", 32'(done_cnt_a - db), 32'd1);

        // Interrupt held during GAP must not shortcut the start write or WAIT_IRQ.
        wb = wa_addr_a.size(); rb = rv_a.size(); sb = rise_a.size();
        pulse_a();
        wait_rv_a(rb + 1);
        tick(1);
        irq_a = 1'b1;
        wait_rise_a(sb + 2);
        irq_a = 1'b0;
        wait_rv_a(rb + 2);
        tick(5);
        check("early_irq_no_clear", 32'(wa_addr_a.size() - wb), 32'd2);
        check("early_irq_busy", 32'(busy_a), 32'd1);
        irq_a = 1'b1; irq_cyc = cyc;
        wait_done_a();
        irq_a = 1'b0;
        tick(2);
        check_seq(0, wb);
        if (rise_a.size() >= sb + 3)
            check("early_irq_clear_time", 32'(rise_a[sb + 2]), 32'(irq_cyc + 1));

        // Interrupt never arrives: timeout after 20 WAIT_IRQ cycles.
        wb = wa_addr_a.size(); rb = rv_a.size(); sb = rise_a.size();
        pulse_a();
        wait_rv_a(rb + 2);
        wait_done_a();
        check("timeout_at_done", 32'(to_a), 32'd1);
        if (rise_a.size() >= sb + 3 && rv_a.size() >= rb + 2)
            check("timeout_wait_len", 32'(rise_a[sb + 2] - rv_a[rb + 1]), 32'd21);
        tick(2);
        check_seq(0, wb);
        check("timeout_sticky", 32'(to_a), 32'd1);
        check("done_low_idle", 32'(done_a), 32'd0);
        check("idle_not_busy", 32'(busy_a), 32'd0);

        // Next launch clears the flag; a launch while busy is ignored.
        wb = wa_addr_a.size(); rb = rv_a.size(); db = done_cnt_a;
        pulse_a();
        check("timeout_cleared", 32'(to_a), 32'd0);
        wait_rv_a(rb + 1);
        tick(1);
        pulse_a();
        wait_rv_a(rb + 2);
        irq_a = 1'b1;
        wait_done_a();
        irq_a = 1'b0;
        tick(20);
        check_seq(0, wb);
        check("ignored_launch_done", 32'(done_cnt_a - db), 32'd1);
        check("ignored_launch_idle", 32'(busy_a), 32'd0);

        // Reset during a stalled start-write address phase.
        stall_req_a = 1000;
        wb = wa_addr_a.size();
        pulse_a();
        wait_req4_a();
        tick(2);
        rst = 1'b1;
        tick(1);
        check("rst_mid_req", 32'(obi_a.req_o), 32'd0);
        check("rst_mid_busy", 32'(busy_a), 32'd0);
        check("rst_mid_addr", obi_a.addr_o, 32'd0);
        rst = 1'b0;
        stall_req_a = 0;
        tick(3);
        check("rst_no_retry", 32'(wa_addr_a.size() - wb), 32'd1);
        wb = wa_addr_a.size(); rb = rv_a.size();
        pulse_a();
        wait_rv_a(rb + 2);
        irq_a = 1'b1;
        wait_done_a();
        irq_a = 1'b0;
        tick(2);
        check_seq(0, wb);

        // GAP_CYCLES=0 and no timeout on the second instance.
        wb = wa_addr_b.size(); rb = rv_b.size(); sb = rise_b.size(); db = done_cnt_b;
        pulse_b();
        wait_rv_b(rb + 2);
        if (rise_b.size() >= sb + 2 && rv_b.size() >= rb + 1)
            check("b2b_start_latency", 32'(rise_b[sb + 1] - rv_b[rb]), 32'd1);
        tick(40);
        check("no_timeout_wait", 32'(wa_addr_b.size() - wb), 32'd2);
        check("no_timeout_busy", 32'(busy_b), 32'd1);
        irq_b = 1'b1;
        wait_done_b();
        irq_b = 1'b0;
        tick(2);
        check_seq(1, wb);
        check("b_done_pulses", 32'(done_cnt_b - db), 32'd1);
        check("b_no_timeout", 32'(to_b), 32'd0);

        check("idle_bus_zero", 32'(idle_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gpu_launch_ctrl.md
GPU_LAUNCH_CTRL -- requirements
Module: gpu_launch_ctrl

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 50: idle cycles between the enable write and the start write.
REQ-002 The block SHALL have parameter IRQ_TIMEOUT, default 0: maximum cycles to wait for the interrupt; 0 disables the timeout.
REQ-003 The block SHALL have the port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have the port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port launch_i, input, 1 bit: pulse that requests one kernel launch.
REQ-006 The block SHALL have the port interrupt_i, input, 1 bit: level-sensitive GPU completion interrupt.
REQ-007 The block SHALL have the port req_o, input/output pair req_o output 1 bit, and gnt_i input 1 bit: the OBI request and grant toward the GPU configuration registers.
REQ-008 The block SHALL have the ports we_o (output, 1 bit), be_o (output, 4 bits), addr_o (output, 32 bits) and wdata_o (output, 32 bits): the OBI write-enable, byte-enable, address and write data.
REQ-009 The block SHALL have the port rvalid_i, input, 1 bit: OBI response valid; rdata is not used.
REQ-010 The block SHALL have the ports busy_o, done_o and timeout_o, each output, 1 bit: status outputs.

Function
REQ-011 The state machine SHALL have the states IDLE, WR_EN, GAP, WR_START, WAIT_IRQ, WR_CLR and DONE.
REQ-012 In IDLE, a launch_i pulse SHALL move the machine to WR_EN on the next edge; launch_i in any other state SHALL be ignored.
REQ-013 The write states SHALL issue these single writes, each with we_o=1 and be_o=4'b1111:
- WR_EN: addr 0x0, data 1.
- WR_START: addr 0x4, data 1.
- WR_CLR: addr 0x8, data 1.
REQ-014 Each write SHALL have an address phase followed by a response phase.
REQ-015 In the address phase, req_o SHALL be 1, and addr_o/wdata_o/we_o/be_o SHALL be held stable until a cycle in which gnt_i=1.
REQ-016 req_o SHALL be 0 from the cycle after the grant.
REQ-017 In the response phase, the block SHALL wait for rvalid_i=1; rvalid_i is sampled only from the cycle after the grant.
REQ-018 When not in an address phase, req_o SHALL be 0 and addr_o/wdata_o/we_o/be_o SHALL be 0.
REQ-019 After the WR_EN response, the machine SHALL enter GAP for exactly GAP_CYCLES cycles, then WR_START; GAP_CYCLES=0 SHALL skip GAP entirely.
REQ-020 After the WR_START response, the machine SHALL enter WAIT_IRQ.
REQ-021 interrupt_i SHALL be sampled only in WAIT_IRQ; interrupt_i=1 SHALL move the machine to WR_CLR on the next edge, and interrupt_i asserted in earlier states SHALL be ignored.
REQ-022 With IRQ_TIMEOUT>0, if interrupt_i stays low for IRQ_TIMEOUT cycles in WAIT_IRQ, the machine SHALL go to WR_CLR and set a sticky timeout flag.
REQ-023 If interrupt_i=1 in the same cycle the timeout expires, the interrupt SHALL win and no timeout SHALL be flagged.
REQ-024 After the WR_CLR response, the machine SHALL go to DONE for one cycle and then to IDLE.
REQ-025 done_o SHALL be 1 only while in DONE.
REQ-026 timeout_o SHALL equal the sticky timeout flag; the flag SHALL be cleared on the next accepted launch_i.
REQ-027 busy_o SHALL be 1 in every state except IDLE.
REQ-028 The GAP and timeout counters SHALL be 32 bits, count down, and saturate at 0 without wrapping.

Reset
REQ-029 While rst_i=1 at a clock edge, the block SHALL set state to IDLE, set all outputs to 0, clear both counters and clear the timeout flag.
REQ-030 A reset during any phase, including mid-handshake, SHALL abandon the transaction with no retry; req_o SHALL be 0 from the reset edge onward.

Structure
REQ-031 A shared package SHALL hold the state enum and the constants CONF_ENABLE_ADDR=0x0, CONF_START_ADDR=0x4 and CONF_CLEAR_ADDR=0x8.
REQ-032 The OBI single-write handshake SHALL be implemented in a sub-module obi_single_write with ports go, addr, wdata, done, and it SHALL be instantiated once and reused by all three write states.

Verification
REQ-033 Zero-wait-state OBI: with gnt_i tied to 1, rvalid_i 1 cycle after gnt, GAP_CYCLES=3, and interrupt_i raised 10 cycles after the start write:
- The bench SHALL see writes in the order (0x0,1), (0x4,1), (0x8,1).
- The start write's req_o SHALL rise exactly 4 cycles after the enable write's rvalid cycle.
- done_o SHALL pulse once.
REQ-034 Stalled grant: with gnt_i held low for 5 cycles on the WR_START write, req_o and addr_o=0x4 SHALL stay stable for 6 cycles, and only one write SHALL occur.
REQ-035 Timeout: with IRQ_TIMEOUT=20 and interrupt_i never raised, the clear write SHALL issue after 20 WAIT_IRQ cycles, and timeout_o=1 and done_o=1 SHALL follow.
REQ-036 Early interrupt: with interrupt_i=1 during GAP, the block SHALL still wait, issue the start write, and issue the clear write only after WAIT_IRQ samples interrupt_i=1.
REQ-037 Reset mid-write: with rst_i=1 during the WR_START address phase, req_o SHALL be 0 at the next edge, the state SHALL be IDLE, and a later launch_i SHALL redo the full sequence from 0x0.
REQ-038 Ignored launch: a launch_i pulse while busy_o=1 SHALL produce no extra writes, and GAP_CYCLES=0 SHALL produce back-to-back enable and start writes.
